// File: rtl/qspi_pkg.sv
// qspi_pkg: shared widths and transmit-unpacker state encodings.
package qspi_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {TX_IDLE, TX_FETCH, TX_SEND, TX_DONE} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with registered read data and flush.
module sync_fifo
    import qspi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WORD_W-1:0]            wr_data,
    input  logic                         pop,
    output logic [WORD_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic do_push, do_pop;
    assign full    = count == LW'(DEPTH);
    assign empty   = count == '0;
    assign level   = count;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else if (do_pop) rd_data <= mem[rd_ptr];
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/fifo_tx_unpack.sv
// fifo_tx_unpack: buffers 32-bit words and unpacks them into a counted byte
// stream with valid/ready toward the QSPI FSM.
module fifo_tx_unpack
    import qspi_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [WORD_W-1:0]            wr_data_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    input  logic                         flush_i,
    input  logic                         start_i,
    input  logic [CNT_W-1:0]             byte_count_i,
    output logic                         byte_valid_o,
    output logic [BYTE_W-1:0]            byte_data_o,
    output logic                         byte_last_o,
    input  logic                         byte_ready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         underrun_o
);
    tx_state_t state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [1:0] idx, lane;
    logic [WORD_W-1:0] word;
    logic pop, hs;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush_i),
        .push    (wr_en_i),
        .wr_data (wr_data_i),
        .pop     (pop),
        .rd_data (word),
        .full    (full_o),
        .empty   (empty_o),
        .level   (level_o)
    );

    assign pop          = state == TX_FETCH && !empty_o;
    assign hs           = byte_valid_o && byte_ready_i;
    assign lane         = BIG_ENDIAN ? ~idx : idx;
    assign byte_valid_o = state == TX_SEND;
    assign byte_data_o  = word[{lane, 3'b000} +: BYTE_W];
    assign byte_last_o  = byte_valid_o && remaining == CNT_W'(1);
    assign busy_o       = state != TX_IDLE;
    assign done_o       = state == TX_DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (start_i) state_nxt = byte_count_i != '0 ? TX_FETCH : TX_DONE;
            TX_FETCH: if (!empty_o) state_nxt = TX_SEND;
            TX_SEND:  if (hs) state_nxt = byte_last_o ? TX_DONE
                                        : idx == 2'(BYTES_PER_WORD - 1) ? TX_FETCH : TX_SEND;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    // Flush shares the reset path: a same-cycle push is also dropped inside the FIFO.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state      <= TX_IDLE;
            remaining  <= '0;
            idx        <= '0;
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_en_i && full_o) overflow_o <= 1'b1;
            if (state == TX_IDLE && start_i && byte_count_i != '0) begin
                remaining  <= byte_count_i;
                underrun_o <= 1'b0;
            end
            if (state == TX_FETCH && empty_o && byte_ready_i) underrun_o <= 1'b1;
            if (pop) idx <= '0;
            if (hs) begin
                remaining <= remaining - CNT_W'(1);
                idx       <= idx + 2'd1;
            end
        end
    end
endmodule
